axis_reg_slice: RTL and testbench



---
 rtl/axis_reg_slice_pkg.sv | 28 ++
 rtl/axis_if.sv | 13 +
 rtl/axis_reg_slice.sv | 120 ++++++++++++
 tb/tb_axis_reg_slice.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/axis_reg_slice_pkg.sv
// Shared definitions for the AXI-Stream register slice: default payload width,
// occupancy encoding and the handshake helper.
package axis_reg_slice_pkg;

    localparam int AXIS_TDATA_WIDTH_DEFAULT = 32;

    // How many beats the slice currently holds (skid build uses all three).
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_MAIN  = 2'd1,
        OCC_FULL  = 2'd2
    } occupancy_t;

    function automatic logic fire(input logic valid, input logic ready);
        return valid && ready;
    endfunction

    function automatic occupancy_t occupancy(input logic main_valid, input logic skid_valid);
        if (skid_valid) begin
            return OCC_FULL;
        end
        if (main_valid) begin
            return OCC_MAIN;
        end
        return OCC_EMPTY;
    endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle: tvalid/tdata flow from the m side, tready from the s side.
interface axis_if #(
    parameter int TDATA_WIDTH = axis_reg_slice_pkg::AXIS_TDATA_WIDTH_DEFAULT
) ();

    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;

    modport m (output tvalid, output tdata, input tready);
    modport s (input tvalid, input tdata, output tready);

endinterface

// File: rtl/axis_reg_slice.sv
// Single-stage AXI-Stream register slice with synchronous flush (invalidate).
// Define AXIS_SLICE_SKID_EN to add a skid entry and make upstream tready fully registered.
module axis_reg_slice
    import axis_reg_slice_pkg::*;
(
    input  logic clk,
    input  logic rst,
    axis_if.s    axis_sif,
    axis_if.m    axis_mif,
    input  logic invalidate
);

    localparam int W = $bits(axis_mif.tdata);

    logic         valid_q;
    logic         valid_next;
    logic [W-1:0] data_q;
    logic [W-1:0] data_next;
    logic         accept;
    logic         drain;

    // Flush masks delivery combinationally; the held payload itself is left alone.
    assign axis_mif.tvalid = valid_q && !invalidate;
    assign axis_mif.tdata  = data_q;

    assign accept = fire(axis_sif.tvalid, axis_sif.tready);
    assign drain  = fire(axis_mif.tvalid, axis_mif.tready);

`ifdef AXIS_SLICE_SKID_EN

    logic         skid_valid_q;
    logic         skid_valid_next;
    logic [W-1:0] skid_data_q;
    logic [W-1:0] skid_data_next;

    assign axis_sif.tready = !skid_valid_q && !invalidate;

    always_comb begin
        valid_next      = valid_q;
        data_next       = data_q;
        skid_valid_next = skid_valid_q;
        skid_data_next  = skid_data_q;
        if (invalidate) begin
            valid_next      = 1'b0;
            skid_valid_next = 1'b0;
        end else begin
            case (occupancy(valid_q, skid_valid_q))
                OCC_EMPTY: begin
                    if (accept) begin
                        valid_next = 1'b1;
                        data_next  = axis_sif.tdata;
                    end
                end
                OCC_MAIN: begin
                    if (drain) begin
                        valid_next = accept;
                        if (accept) begin
                            data_next = axis_sif.tdata;
                        end
                    end else if (accept) begin
                        skid_valid_next = 1'b1;
                        skid_data_next  = axis_sif.tdata;
                    end
                end
                default: begin
                    // Both entries full: tready is low, so only a drain can happen.
                    if (drain) begin
                        data_next       = skid_data_q;
                        skid_valid_next = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            data_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            valid_q      <= valid_next;
            data_q       <= data_next;
            skid_valid_q <= skid_valid_next;
            skid_data_q  <= skid_data_next;
        end
    end

`else

    // Ready looks through to the consumer so a full slice can refill while draining.
    assign axis_sif.tready = (!valid_q || axis_mif.tready) && !invalidate;

    always_comb begin
        valid_next = valid_q;
        data_next  = data_q;
        if (invalidate) begin
            valid_next = 1'b0;
        end else if (accept) begin
            valid_next = 1'b1;
            data_next  = axis_sif.tdata;
        end else if (drain) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_next;
            data_q  <= data_next;
        end
    end

`endif

endmodule

// File: tb/tb_axis_reg_slice.sv
// Self-checking bench for axis_reg_slice: reset, directed vector table, streaming,
// randomized traffic against a queue model, and reset in mid-transfer.
module tb_axis_reg_slice;

`ifdef AXIS_SLICE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct {
        logic        s_tvalid;
        logic [31:0] s_tdata;
        logic        m_tready;
        logic        inv;
        logic        e_tvalid;
        logic [31:0] e_tdata;
        logic        e_tready;
    } vec_t;

    logic clk;
    logic rst;
    logic invalidate;

    axis_if #(.TDATA_WIDTH(32)) up ();
    axis_if #(.TDATA_WIDTH(32)) down ();

    axis_reg_slice dut (
        .clk        (clk),
        .rst        (rst),
        .axis_sif   (up),
        .axis_mif   (down),
        .invalidate (invalidate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic sv, input logic [31:0] sd, input logic mr, input logic iv,
                       input logic ev, input logic [31:0] ed, input logic er);
        vec_t v;
        v.s_tvalid = sv; v.s_tdata = sd; v.m_tready = mr; v.inv = iv;
        v.e_tvalid = ev; v.e_tdata = ed; v.e_tready = er;
        vecs.push_back(v);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] q[$];
        logic        pend;
        logic [31:0] pend_data;
        logic        exp_tv;
        logic        exp_tr;

        // ---------------- reset with upstream offering a beat ----------------
        rst = 1'b1; invalidate = 1'b0;
        up.tvalid = 1'b1; up.tdata = 32'hDEADBEEF; down.tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            check("rst_tvalid", {31'b0, down.tvalid}, 32'd0);
            check("rst_tdata", down.tdata, 32'd0);
        end
        next_cycle();
        rst = 1'b0; up.tvalid = 1'b0;
        #1;
        check("post_rst_tvalid", {31'b0, down.tvalid}, 32'd0);
        check("post_rst_tdata", down.tdata, 32'd0);
        check("post_rst_tready", {31'b0, up.tready}, 32'd1);

        // ---------------- directed vector table ----------------
        // single beat
        add(1, 32'h11, 1, 0, 0, 32'h00, 1);
        add(0, 32'h00, 1, 0, 1, 32'h11, 1);
        add(0, 32'h00, 1, 0, 0, 32'h11, 1);
        // backpressure: 0x22 held for 10 stalled cycles, 0x33 offered behind it
        add(1, 32'h22, 0, 0, 0, 32'h11, 1);
        add(1, 32'h33, 0, 0, 1, 32'h22, SKID);
        for (int i = 0; i < 9; i++) add(!SKID, 32'h33, 0, 0, 1, 32'h22, 0);
        add(!SKID, 32'h33, 1, 0, 1, 32'h22, !SKID);
        add(0, 32'h00, 1, 0, 1, 32'h33, 1);
        add(0, 32'h00, 1, 0, 0, 32'h33, 1);
        // flush while holding 0x44 with 0x55 offered
        add(1, 32'h44, 0, 0, 0, 32'h33, 1);
        add(1, 32'h55, 0, 1, 0, 32'h44, 0);
        add(1, 32'h55, 0, 0, 0, 32'h44, 1);
        add(0, 32'h00, 1, 0, 1, 32'h55, 1);
        add(0, 32'h00, 1, 0, 0, 32'h55, 1);
        // flush with a ready consumer: 0x66 is discarded, 0x77 not accepted
        add(1, 32'h66, 1, 0, 0, 32'h55, 1);
        add(1, 32'h77, 1, 1, 0, 32'h66, 0);
        add(0, 32'h00, 1, 0, 0, 32'h66, 1);

        foreach (vecs[i]) begin
            next_cycle();
            up.tvalid = vecs[i].s_tvalid; up.tdata = vecs[i].s_tdata;
            down.tready = vecs[i].m_tready; invalidate = vecs[i].inv;
            #1;
            $display("vec %0d: in v=%0b d=%h r=%0b inv=%0b out v=%0b d=%h rdy=%0b", i,
                     up.tvalid, up.tdata, down.tready, invalidate, down.tvalid, down.tdata, up.tready);
            check($sformatf("vec%0d_tvalid", i), {31'b0, down.tvalid}, {31'b0, vecs[i].e_tvalid});
            check($sformatf("vec%0d_tdata", i), down.tdata, vecs[i].e_tdata);
            check($sformatf("vec%0d_tready", i), {31'b0, up.tready}, {31'b0, vecs[i].e_tready});
        end

        // ---------------- streaming 100 beats at full rate ----------------
        for (int i = 0; i <= 100; i++) begin
            next_cycle();
            up.tvalid = (i < 100); up.tdata = i; down.tready = 1'b1; invalidate = 1'b0;
            #1;
            check("stream_tvalid", {31'b0, down.tvalid}, (i > 0) ? 32'd1 : 32'd0);
            if (i > 0) check("stream_tdata", down.tdata, i - 1);
            check("stream_tready", {31'b0, up.tready}, 32'd1);
        end
        next_cycle();
        up.tvalid = 1'b0;
        #1;
        check("stream_end_tvalid", {31'b0, down.tvalid}, 32'd0);

        // ---------------- random traffic against a queue model ----------------
        pend = 1'b0; pend_data = '0;
        for (int c = 0; c < 10000; c++) begin
            next_cycle();
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                pend_data = $urandom;
            end
            up.tvalid   = pend;
            up.tdata    = pend ? pend_data : $urandom;
            down.tready = ($urandom_range(0, 2) != 0);
            invalidate  = ($urandom_range(0, 63) == 0);
            #1;
            exp_tv = (q.size() > 0) && !invalidate;
            exp_tr = (SKID ? (q.size() < 2) : (q.size() == 0 || down.tready)) && !invalidate;
            check("rnd_tvalid", {31'b0, down.tvalid}, {31'b0, exp_tv});
            check("rnd_tready", {31'b0, up.tready}, {31'b0, exp_tr});
            if (exp_tv) check("rnd_tdata", down.tdata, q[0]);
            if (invalidate) begin
                q.delete();
            end else begin
                if (exp_tv && down.tready) void'(q.pop_front());
                if (up.tvalid && exp_tr) q.push_back(up.tdata);
            end
            if (up.tvalid && exp_tr) pend = 1'b0;
        end

        // ---------------- reset in the middle of a stalled transfer ----------------
        next_cycle();
        up.tvalid = 1'b1; up.tdata = 32'hAB; down.tready = 1'b0; invalidate = 1'b0; rst = 1'b1;
        next_cycle();
        #1;
        check("midrst_tvalid", {31'b0, down.tvalid}, 32'd0);
        check("midrst_tdata", down.tdata, 32'd0);
        rst = 1'b0; up.tvalid = 1'b0;
        #1;
        check("midrst_tready", {31'b0, up.tready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
